alu_arbiter: RTL

Two-requester round-robin arbiter and sequencer that shares one combinational 16-bit `alu` instance between two clients. It accepts one operation at a time on valid/ready request channels and drives the operands onto the shared ALU from registers. It captures the ALU result, carry and compare flags, and returns them on the granted client's valid/ready response channel. It sits between the `alu` and its users (for example, a decode stage and a DMA address generator).

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester round-robin sequencer sharing one combinational ALU
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [3:0]       req_sel_0,
  input  logic             req_mode_0,
  input  logic             req_cin_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_sel_1,
  input  logic             req_mode_1,
  input  logic             req_cin_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_data_0,
  output logic             rsp_cout_0,
  output logic             rsp_cmp_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data_1,
  output logic             rsp_cout_1,
  output logic             rsp_cmp_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_mode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_cmp,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             cin_q, cin_d;
  logic             g_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             cmp_q;
  logic [15:0]      op_count_q;

  logic win;
  logic req_hs;
  logic rsp_hs;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    win    = 1'b0;
    req_hs = 1'b0;
    rsp_hs = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      win = ~last_grant_q;
    end else begin
      win = req_valid_1;
    end
    req_hs = rst && (state_q == S_IDLE) && (req_valid_0 || req_valid_1);
    rsp_hs = rst && (state_q == S_RESP) && (g_q ? rsp_ready_1 : rsp_ready_0);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          state_d = S_ISSUE;
          a_d     = win ? req_a_1    : req_a_0;
          b_d     = win ? req_b_1    : req_b_0;
          sel_d   = win ? req_sel_1  : req_sel_0;
          mode_d  = win ? req_mode_1 : req_mode_0;
          cin_d   = win ? req_cin_1  : req_cin_0;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= 4'd0;
      mode_q       <= 1'b0;
      cin_q        <= 1'b0;
      g_q          <= 1'b0;
      last_grant_q <= 1'b1;
      res_q        <= '0;
      cout_q       <= 1'b0;
      cmp_q        <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      if (req_hs) begin
        g_q <= win;
      end
      // The ALU is combinational, so its outputs are valid in the ISSUE cycle.
      if (state_q == S_ISSUE) begin
        res_q        <= alu_out;
        cout_q       <= alu_cout;
        cmp_q        <= alu_cmp;
        last_grant_q <= g_q;
      end
      if (rsp_hs) begin
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign req_ready_0 = req_hs && !win;
  assign req_ready_1 = req_hs && win;

  assign rsp_valid_0 = rst && (state_q == S_RESP) && !g_q;
  assign rsp_valid_1 = rst && (state_q == S_RESP) && g_q;
  assign rsp_data_0  = res_q;
  assign rsp_cout_0  = cout_q;
  assign rsp_cmp_0   = cmp_q;
  assign rsp_data_1  = res_q;
  assign rsp_cout_1  = cout_q;
  assign rsp_cmp_1   = cmp_q;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_sel  = sel_q;
  assign alu_mode = mode_q;
  assign alu_cin  = cin_q;

  assign busy     = rst && (state_q != S_IDLE);
  assign op_count = op_count_q;

endmodule

`default_nettype wire
